// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and request bundle for the dmem arbiter.
// Also carries the per-master hready selection used by the top.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int AHB_AW = 32;

  typedef struct packed {
    logic [1:0]        htrans;
    logic [AHB_AW-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
  } ahb_req_t;

  // A held response is released only when that master's next
  // address is accepted, so the data and address phases move together.
  function automatic logic arb_hready(
    input logic hv,
    input logic dat,
    input logic req,
    input logic gnt,
    input logic shr
  );
    if (hv)
      return gnt & shr;
    else if (dat & !req)
      return shr;
    else if (dat)
      return shr & gnt;
    else if (req & !gnt)
      return 1'b0;
    else
      return shr;
  endfunction

endpackage

// File: rtl/ahb_dmem_arbiter_if.sv
// One AHB-Lite port: the arbiter is the slave on each master side
// and the master on the dmem side.
interface ahb_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hresp;
  logic [DW-1:0] hrdata;

  modport master (
    output htrans,
    output haddr,
    output hwrite,
    output hsize,
    output hwdata,
    input  hready,
    input  hresp,
    input  hrdata
  );

  modport slave (
    input  htrans,
    input  haddr,
    input  hwrite,
    input  hsize,
    input  hwdata,
    output hready,
    output hresp,
    output hrdata
  );

endinterface

// File: rtl/ahb_arb_hold_buf.sv
// Per-master response hold buffer: parks a completed data phase
// until the master's stalled next address is granted.
module ahb_arb_hold_buf
  import ahb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          set,
  input  logic          clr,
  input  logic [DW-1:0] rdata,
  input  logic          resp,
  output logic          hold_vld,
  output logic [DW-1:0] hold_rdata,
  output logic          hold_resp
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_vld   <= 1'b0;
      hold_rdata <= '0;
      hold_resp  <= HRESP_OKAY;
    end else if (set) begin
      hold_vld   <= 1'b1;
      hold_rdata <= rdata;
      hold_resp  <= resp;
    end else if (clr) begin
      hold_vld   <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_dmem_arbiter.sv
// Two-master AHB-Lite arbiter in front of the dmem slave.
// M0 is the core data bus, M1 a loader/DMA/debug master.
module ahb_dmem_arbiter
  import ahb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic                clk,
  input  logic                rst_b,
  ahb_dmem_arbiter_if.slave   m0,
  ahb_dmem_arbiter_if.slave   m1,
  ahb_dmem_arbiter_if.master  s,
  output logic                arb_owner
);

  logic a_own;
  logic d_own;
  logic d_vld;
  logic last_grant;
  logic grant;

  logic req0;
  logic req1;
  logic req_g;
  logic lock;
  logic solo;
  logic both;

  ahb_req_t r0;
  ahb_req_t r1;
  ahb_req_t rg;

  logic          dat0;
  logic          dat1;
  logic          set0;
  logic          set1;
  logic          clr0;
  logic          clr1;
  logic          hv0;
  logic          hv1;
  logic [DW-1:0] hd0;
  logic [DW-1:0] hd1;
  logic          hr0;
  logic          hr1;
  logic          rdy0;
  logic          rdy1;

  assign req0 = m0.htrans[1];
  assign req1 = m1.htrans[1];

  // A SEQ beat from the current owner keeps the bus (burst lock).
  assign lock = a_own ? (m1.htrans == HTRANS_SEQ)
                      : (m0.htrans == HTRANS_SEQ);
  assign solo = !lock & (req0 ^ req1);
  assign both = !lock & req0 & req1;

  always_comb begin
    grant = a_own;
    unique case (1'b1)
      lock:    grant = a_own;
      solo:    grant = req1;
      both:    grant = ROUND_ROBIN ? ~last_grant : 1'b0;
      default: grant = a_own;
    endcase
  end

  assign req_g = grant ? req1 : req0;

  always_comb begin
    r0 = '{htrans: m0.htrans,
           haddr:  AHB_AW'(m0.haddr),
           hwrite: m0.hwrite,
           hsize:  m0.hsize};
    r1 = '{htrans: m1.htrans,
           haddr:  AHB_AW'(m1.haddr),
           hwrite: m1.hwrite,
           hsize:  m1.hsize};
    rg = grant ? r1 : r0;
    if (!req_g)
      rg = '0;
  end

  assign s.htrans = rg.htrans;
  assign s.haddr  = AW'(rg.haddr);
  assign s.hwrite = rg.hwrite;
  assign s.hsize  = rg.hsize;
  assign s.hwdata = d_own ? m1.hwdata : m0.hwdata;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_own      <= 1'b0;
      d_own      <= 1'b0;
      d_vld      <= 1'b0;
      last_grant <= 1'b1;
    end else if (s.hready) begin
      a_own <= grant;
      d_own <= grant;
      d_vld <= s.htrans[1];
      if (req_g)
        last_grant <= grant;
    end
  end

  assign dat0 = d_vld & ~d_own;
  assign dat1 = d_vld &  d_own;

  // Capture when the data phase ends but the next address lost.
  assign set0 = s.hready & dat0 & req0 &  grant;
  assign set1 = s.hready & dat1 & req1 & ~grant;
  assign clr0 = hv0 & rdy0;
  assign clr1 = hv1 & rdy1;

  ahb_arb_hold_buf #(.DW(DW)) u_hold0 (
    .clk        (clk),
    .rst_b      (rst_b),
    .set        (set0),
    .clr        (clr0),
    .rdata      (s.hrdata),
    .resp       (s.hresp),
    .hold_vld   (hv0),
    .hold_rdata (hd0),
    .hold_resp  (hr0)
  );

  ahb_arb_hold_buf #(.DW(DW)) u_hold1 (
    .clk        (clk),
    .rst_b      (rst_b),
    .set        (set1),
    .clr        (clr1),
    .rdata      (s.hrdata),
    .resp       (s.hresp),
    .hold_vld   (hv1),
    .hold_rdata (hd1),
    .hold_resp  (hr1)
  );

  assign rdy0 = arb_hready(hv0, dat0, req0, ~grant, s.hready);
  assign rdy1 = arb_hready(hv1, dat1, req1,  grant, s.hready);

  assign m0.hready = rdy0;
  assign m1.hready = rdy1;

  assign m0.hrdata = hv0  ? hd0
                   : dat0 ? s.hrdata : '0;
  assign m1.hrdata = hv1  ? hd1
                   : dat1 ? s.hrdata : '0;
  assign m0.hresp  = hv0  ? hr0
                   : dat0 ? s.hresp : HRESP_OKAY;
  assign m1.hresp  = hv1  ? hr1
                   : dat1 ? s.hresp : HRESP_OKAY;

  assign arb_owner = a_own;

endmodule

// File: tb/tb_ahb_dmem_arbiter.sv
// Directed bench for ahb_dmem_arbiter: contention, burst lock,
// hold buffer, error response and reset mid-burst.
module tb_ahb_dmem_arbiter;
  import ahb_pkg::*;

  logic clk;
  logic rst_b;
  logic arb_owner;
  int   checks;
  int   errors;

  ahb_dmem_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
  ahb_dmem_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
  ahb_dmem_arbiter_if #(.AW(32), .DW(32)) s_bus ();

  ahb_dmem_arbiter #(
    .ROUND_ROBIN (1'b1),
    .AW          (32),
    .DW          (32)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .arb_owner (arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_drv(input logic [1:0] t,
                        input logic [31:0] a,
                        input logic w);
    m0_bus.htrans = t;
    m0_bus.haddr  = a;
    m0_bus.hwrite = w;
    m0_bus.hsize  = t[1] ? 3'b010 : 3'b000;
  endtask

  task automatic m1_drv(input logic [1:0] t,
                        input logic [31:0] a,
                        input logic w);
    m1_bus.htrans = t;
    m1_bus.haddr  = a;
    m1_bus.hwrite = w;
    m1_bus.hsize  = t[1] ? 3'b010 : 3'b000;
  endtask

  task automatic slv(input logic rdy,
                     input logic rsp,
                     input logic [31:0] d);
    s_bus.hready = rdy;
    s_bus.hresp  = rsp;
    s_bus.hrdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b  = 1'b0;
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    m0_bus.hwdata = '0;
    m1_bus.hwdata = '0;
    slv(1'b1, 1'b0, 32'hDEAD_BEEF);
    #12;
    chk("rst_m0_hready", m0_bus.hready, 1);
    chk("rst_m1_hready", m1_bus.hready, 1);
    chk("rst_m0_hresp", m0_bus.hresp, 0);
    chk("rst_m0_hrdata", m0_bus.hrdata, 0);
    chk("rst_m1_hrdata", m1_bus.hrdata, 0);
    chk("rst_s_htrans", s_bus.htrans, 0);
    chk("rst_s_haddr", s_bus.haddr, 0);
    chk("rst_s_hwdata", s_bus.hwdata, 0);
    chk("rst_owner", arb_owner, 0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // contention: M0 first, M1 next
    m0_drv(HTRANS_NONSEQ, 32'h100, 1'b0);
    m1_drv(HTRANS_NONSEQ, 32'h200, 1'b0);
    slv(1'b1, 1'b0, 32'h0);
    #1;
    chk("c1_s_haddr", s_bus.haddr, 32'h100);
    chk("c1_m0_hready", m0_bus.hready, 1);
    chk("c1_m1_hready", m1_bus.hready, 0);
    tick();
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'h1111_0000);
    #1;
    chk("c2_s_haddr", s_bus.haddr, 32'h200);
    chk("c2_m0_hrdata", m0_bus.hrdata, 32'h1111_0000);
    chk("c2_m0_hready", m0_bus.hready, 1);
    chk("c2_m1_hready", m1_bus.hready, 1);
    chk("c2_m1_hrdata", m1_bus.hrdata, 0);
    tick();
    chk("c3_owner", arb_owner, 1);
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'h2222_0000);
    #1;
    chk("c3_m1_hrdata", m1_bus.hrdata, 32'h2222_0000);
    chk("c3_m0_hrdata", m0_bus.hrdata, 0);
    tick();

    // solo M0 read, zero stalls
    m0_drv(HTRANS_NONSEQ, 32'h6000_0010, 1'b0);
    #1;
    chk("solo_s_htrans", s_bus.htrans, 2);
    chk("solo_s_haddr", s_bus.haddr, 32'h6000_0010);
    chk("solo_m0_hready_a", m0_bus.hready, 1);
    tick();
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'hA5A5_0001);
    #1;
    chk("solo_m0_hrdata", m0_bus.hrdata, 32'hA5A5_0001);
    chk("solo_m0_hready_d", m0_bus.hready, 1);
    tick();

    // repeat contention: M1 first, then M0
    m0_drv(HTRANS_NONSEQ, 32'h300, 1'b0);
    m1_drv(HTRANS_NONSEQ, 32'h400, 1'b0);
    #1;
    chk("r1_s_haddr", s_bus.haddr, 32'h400);
    chk("r1_m0_hready", m0_bus.hready, 0);
    chk("r1_m1_hready", m1_bus.hready, 1);
    tick();
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'h3333_0000);
    #1;
    chk("r2_s_haddr", s_bus.haddr, 32'h300);
    chk("r2_m0_hready", m0_bus.hready, 1);
    chk("r2_m1_hrdata", m1_bus.hrdata, 32'h3333_0000);
    tick();
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'h4444_0000);
    #1;
    chk("r3_m0_hrdata", m0_bus.hrdata, 32'h4444_0000);
    tick();

    // burst lock: M1 4-beat burst, M0 asks from beat 2
    m1_drv(HTRANS_NONSEQ, 32'h500, 1'b0);
    tick();
    m1_drv(HTRANS_SEQ, 32'h504, 1'b0);
    m0_drv(HTRANS_NONSEQ, 32'h600, 1'b0);
    #1;
    chk("b2_s_haddr", s_bus.haddr, 32'h504);
    chk("b2_m0_hready", m0_bus.hready, 0);
    tick();
    m1_drv(HTRANS_SEQ, 32'h508, 1'b0);
    #1;
    chk("b3_m0_hready", m0_bus.hready, 0);
    tick();
    m1_drv(HTRANS_SEQ, 32'h50C, 1'b0);
    #1;
    chk("b4_s_haddr", s_bus.haddr, 32'h50C);
    chk("b4_m0_hready", m0_bus.hready, 0);
    tick();
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    #1;
    chk("b5_s_haddr", s_bus.haddr, 32'h600);
    chk("b5_m0_hready", m0_bus.hready, 1);
    chk("b5_m1_hready", m1_bus.hready, 1);
    tick();
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    tick();

    // hold buffer on M0
    m0_drv(HTRANS_NONSEQ, 32'h700, 1'b0);
    tick();
    m0_drv(HTRANS_NONSEQ, 32'h704, 1'b0);
    m1_drv(HTRANS_NONSEQ, 32'h800, 1'b0);
    slv(1'b1, 1'b0, 32'h1234_5678);
    #1;
    chk("h1_s_haddr", s_bus.haddr, 32'h800);
    chk("h1_m0_hready", m0_bus.hready, 0);
    chk("h1_m0_hrdata", m0_bus.hrdata, 32'h1234_5678);
    tick();
    chk("h2_hold_vld0", dut.u_hold0.hold_vld, 1);
    m1_drv(HTRANS_SEQ, 32'h804, 1'b0);
    slv(1'b1, 1'b0, 32'hBBBB_0001);
    #1;
    chk("h2_m0_hready", m0_bus.hready, 0);
    chk("h2_m0_hrdata", m0_bus.hrdata, 32'h1234_5678);
    chk("h2_m1_hrdata", m1_bus.hrdata, 32'hBBBB_0001);
    tick();
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'hBBBB_0002);
    #1;
    chk("h3_s_haddr", s_bus.haddr, 32'h704);
    chk("h3_m0_hready", m0_bus.hready, 1);
    chk("h3_m0_hrdata", m0_bus.hrdata, 32'h1234_5678);
    chk("h3_m1_hrdata", m1_bus.hrdata, 32'hBBBB_0002);
    tick();
    chk("h4_hold_vld0", dut.u_hold0.hold_vld, 0);
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    slv(1'b1, 1'b0, 32'h5555_0000);
    #1;
    chk("h4_m0_hrdata", m0_bus.hrdata, 32'h5555_0000);
    tick();

    // ERROR on an M1 write, M0 keeps an OKAY path
    m1_drv(HTRANS_NONSEQ, 32'h6000_FFF8, 1'b1);
    #1;
    chk("e0_s_hwrite", s_bus.hwrite, 1);
    tick();
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    m1_bus.hwdata = 32'hCAFE_F00D;
    m0_drv(HTRANS_NONSEQ, 32'h900, 1'b0);
    slv(1'b0, 1'b1, 32'h0);
    #1;
    chk("e1_s_hwdata", s_bus.hwdata, 32'hCAFE_F00D);
    chk("e1_m1_hresp", m1_bus.hresp, 1);
    chk("e1_m1_hready", m1_bus.hready, 0);
    chk("e1_m0_hresp", m0_bus.hresp, 0);
    tick();
    slv(1'b1, 1'b1, 32'h0);
    #1;
    chk("e2_m1_hresp", m1_bus.hresp, 1);
    chk("e2_m1_hready", m1_bus.hready, 1);
    chk("e2_m0_hresp", m0_bus.hresp, 0);
    chk("e2_m0_hready", m0_bus.hready, 1);
    tick();
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    m1_bus.hwdata = '0;
    slv(1'b1, 1'b0, 32'h6666_0000);
    #1;
    chk("e3_m0_hrdata", m0_bus.hrdata, 32'h6666_0000);
    chk("e3_m0_hresp", m0_bus.hresp, 0);
    tick();

    // reset during M0 beat 3 with an M1 response held
    m1_drv(HTRANS_NONSEQ, 32'hB00, 1'b0);
    tick();
    m1_drv(HTRANS_NONSEQ, 32'hB04, 1'b0);
    m0_drv(HTRANS_NONSEQ, 32'hA00, 1'b0);
    slv(1'b1, 1'b0, 32'h7777_0000);
    #1;
    chk("x1_s_haddr", s_bus.haddr, 32'hA00);
    chk("x1_m1_hready", m1_bus.hready, 0);
    tick();
    m0_drv(HTRANS_SEQ, 32'hA04, 1'b0);
    slv(1'b1, 1'b0, 32'h8888_0000);
    #1;
    chk("x2_m1_hready", m1_bus.hready, 0);
    chk("x2_m1_hrdata", m1_bus.hrdata, 32'h7777_0000);
    chk("x2_m0_hrdata", m0_bus.hrdata, 32'h8888_0000);
    tick();
    m0_drv(HTRANS_SEQ, 32'hA08, 1'b0);
    #2;
    rst_b = 1'b0;
    m0_drv(HTRANS_IDLE, 32'h0, 1'b0);
    m1_drv(HTRANS_IDLE, 32'h0, 1'b0);
    #1;
    chk("x3_hold_vld1", dut.u_hold1.hold_vld, 0);
    chk("x3_m1_hrdata", m1_bus.hrdata, 0);
    tick();
    chk("x4_s_htrans", s_bus.htrans, 0);
    chk("x4_hold_vld0", dut.u_hold0.hold_vld, 0);
    chk("x4_hold_vld1", dut.u_hold1.hold_vld, 0);
    chk("x4_m1_hready", m1_bus.hready, 1);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    m0_drv(HTRANS_NONSEQ, 32'hC00, 1'b0);
    m1_drv(HTRANS_NONSEQ, 32'hD00, 1'b0);
    #1;
    chk("x5_s_haddr", s_bus.haddr, 32'hC00);
    chk("x5_m1_hready", m1_bus.hready, 0);
    chk("x5_m0_hready", m0_bus.hready, 1);
    tick();
    chk("x6_owner", arb_owner, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
